// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if
// Bundles the multiplexed display bus being monitored and the change-event
// stream produced by the decoder.
//   scan_valid  sample strobe for seg_in / digit_en
//   seg_in      segment lines, active-high, bit0 = a .. bit6 = g
//   digit_en    one-hot digit enables, active-high
//   out_valid   change event available
//   out_ready   consumer accepts the event
//   out_index   digit that changed
//   out_value   new 3-bit value
//   out_known   new pattern was a legal digit
// Modports: master drives the scan bus and out_ready (display side plus
// consumer); slave is the decoder.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  scan_valid;
  logic [6:0]            seg_in;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_index;
  logic [2:0]            out_value;
  logic                  out_known;

  modport master (
    output scan_valid, seg_in, digit_en, out_ready,
    input  out_valid, out_index, out_value, out_known
  );

  modport slave (
    input  scan_valid, seg_in, digit_en, out_ready,
    output out_valid, out_index, out_value, out_known
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a multiplexed 7-segment display bus and reconstructs the 3-bit
// value shown on each digit. Every sample addressed to a digit passes
// through a per-digit stability filter; values that stay identical for
// STABLE_COUNT samples are committed and reported as change events.
// Ports:
//   clk               single clock
//   reset_n           synchronous, active-low reset
//   bus               scan bus inputs and event stream (slave modport)
//   committed_values  digit d at [4d+3:4d] = {known, value[2:0]}
//   onehot_err        one-cycle pulse: strobe with non-one-hot digit_en
//   overrun           sticky: a pending event was superseded unread
module seg7_scan_decoder #(
  parameter int NUM_DIGITS   = 4,
  parameter int STABLE_COUNT = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  seg7_scan_decoder_if.slave      bus,
  output logic [4*NUM_DIGITS-1:0] committed_values,
  output logic                    onehot_err,
  output logic                    overrun
);

  localparam int         IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] STABLE_CNT = 4'(STABLE_COUNT);

  // Exact-match segment decode; anything else (blank included) is unknown.
  function automatic logic [3:0] decode_seg(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      7'b0111111: code = 4'b1000;
      7'b0000110: code = 4'b1001;
      7'b1011011: code = 4'b1010;
      7'b1001111: code = 4'b1011;
      7'b1100110: code = 4'b1100;
      7'b1101101: code = 4'b1101;
      7'b1111101: code = 4'b1110;
      7'b0000111: code = 4'b1111;
      default:    code = 4'b0000;
    endcase
    return code;
  endfunction

  // True when exactly one enable bit is set.
  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    logic [4:0] ones;
    ones = 5'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ones = ones + {4'd0, v[i]};
    end
    return (ones == 5'd1);
  endfunction

  // Index of the lowest set bit; used both for one-hot enables and for
  // the fixed-priority pick among pending digits.
  function automatic logic [IDX_W-1:0] lowest_set_index(input logic [NUM_DIGITS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Stage 1 registers
  logic             s1_valid_r;
  logic [3:0]       s1_code_r;
  logic [IDX_W-1:0] s1_idx_r;
  logic             onehot_err_r;

  // Stage 2 per-digit filter state
  logic [3:0]            cand_r [NUM_DIGITS];
  logic [3:0]            cnt_r  [NUM_DIGITS];
  logic [3:0]            comm_r [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] pend_r;
  logic                  overrun_r;

  // Output stage registers
  logic             out_valid_r;
  logic [IDX_W-1:0] out_index_r;
  logic [2:0]       out_value_r;
  logic             out_known_r;

  // Combinational next-state terms
  logic                  sample_onehot_s;
  logic [3:0]            cur_cand_s;
  logic [3:0]            cur_cnt_s;
  logic [3:0]            cur_comm_s;
  logic [3:0]            new_cand_s;
  logic [3:0]            new_cnt_s;
  logic                  commit_s;
  logic [IDX_W-1:0]      load_idx_s;
  logic                  load_s;
  logic                  load_same_s;
  logic                  overrun_set_s;
  logic [NUM_DIGITS-1:0] pend_next_s;

  // Enable legality of the current strobe.
  always_comb begin
    sample_onehot_s = is_onehot(bus.digit_en);
  end

  // Stage 1: capture decoded code and digit index of each legal strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_r   <= 1'b0;
      s1_code_r    <= 4'd0;
      s1_idx_r     <= {IDX_W{1'b0}};
      onehot_err_r <= 1'b0;
    end else begin
      s1_valid_r   <= bus.scan_valid && sample_onehot_s;
      onehot_err_r <= bus.scan_valid && !sample_onehot_s;
      if (bus.scan_valid && sample_onehot_s) begin
        s1_code_r <= decode_seg(bus.seg_in);
        s1_idx_r  <= lowest_set_index(bus.digit_en);
      end else begin
        s1_code_r <= s1_code_r;
        s1_idx_r  <= s1_idx_r;
      end
    end
  end

  // Stage 2 filter update for the digit addressed by the stage-1 sample.
  always_comb begin
    cur_cand_s = cand_r[s1_idx_r];
    cur_cnt_s  = cnt_r[s1_idx_r];
    cur_comm_s = comm_r[s1_idx_r];
    new_cand_s = cur_cand_s;
    new_cnt_s  = cur_cnt_s;
    if (s1_code_r == cur_cand_s) begin
      new_cand_s = cur_cand_s;
      if (cur_cnt_s >= STABLE_CNT) begin
        new_cnt_s = STABLE_CNT;
      end else begin
        new_cnt_s = cur_cnt_s + 4'd1;
      end
    end else begin
      new_cand_s = s1_code_r;
      new_cnt_s  = 4'd1;
    end
    commit_s = s1_valid_r && (new_cnt_s == STABLE_CNT) && (new_cand_s != cur_comm_s);
  end

  // Output-stage load decision and pending-bit bookkeeping. A commit to the
  // digit being loaded keeps its pend bit so the newer value follows later.
  always_comb begin
    load_idx_s    = lowest_set_index(pend_r);
    load_s        = (|pend_r) && (!out_valid_r || bus.out_ready);
    load_same_s   = load_s && (load_idx_s == s1_idx_r);
    overrun_set_s = commit_s && pend_r[s1_idx_r] && !load_same_s;
    pend_next_s   = pend_r;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (commit_s && (s1_idx_r == IDX_W'(d))) begin
        pend_next_s[d] = 1'b1;
      end else if (load_s && (load_idx_s == IDX_W'(d))) begin
        pend_next_s[d] = 1'b0;
      end else begin
        pend_next_s[d] = pend_r[d];
      end
    end
  end

  // Stage 2 state: per-digit candidate/counter/committed code, pend, overrun.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        cand_r[d] <= 4'd0;
        cnt_r[d]  <= 4'd0;
        comm_r[d] <= 4'd0;
      end
      pend_r    <= {NUM_DIGITS{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      if (s1_valid_r) begin
        cand_r[s1_idx_r] <= new_cand_s;
        cnt_r[s1_idx_r]  <= new_cnt_s;
      end else begin
        cand_r[s1_idx_r] <= cand_r[s1_idx_r];
        cnt_r[s1_idx_r]  <= cnt_r[s1_idx_r];
      end
      if (commit_s) begin
        comm_r[s1_idx_r] <= new_cand_s;
      end else begin
        comm_r[s1_idx_r] <= comm_r[s1_idx_r];
      end
      pend_r    <= pend_next_s;
      overrun_r <= overrun_r || overrun_set_s;
    end
  end

  // Output stage: event register reads the committed code as it stands
  // at the load edge, and holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_index_r <= {IDX_W{1'b0}};
      out_value_r <= 3'd0;
      out_known_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_index_r <= load_idx_s;
      out_value_r <= comm_r[load_idx_s][2:0];
      out_known_r <= comm_r[load_idx_s][3];
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
      out_index_r <= out_index_r;
      out_value_r <= out_value_r;
      out_known_r <= out_known_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_index_r <= out_index_r;
      out_value_r <= out_value_r;
      out_known_r <= out_known_r;
    end
  end

  // Flatten committed codes onto the snapshot bus.
  always_comb begin
    committed_values = {(4*NUM_DIGITS){1'b0}};
    for (int d = 0; d < NUM_DIGITS; d++) begin
      committed_values[4*d +: 4] = comm_r[d];
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_index = out_index_r;
  assign bus.out_value = out_value_r;
  assign bus.out_known = out_known_r;
  assign onehot_err    = onehot_err_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Scoreboarded bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_COUNT=3).
// A behavioural model tracks per-digit run lengths and committed values;
// expected events go into a queue that a forked monitor drains on each
// accepted handshake.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 3;

  typedef struct {
    int idx;
    int code;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] committed_values;
  logic        onehot_err;
  logic        overrun;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_COUNT(SC)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .committed_values (committed_values),
    .onehot_err       (onehot_err),
    .overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];
  bit   auto_push;
  int   m_cand [ND];
  int   m_cnt  [ND];
  int   m_comm [ND];
  logic [6:0] pat [8];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ref_decode(input logic [6:0] s);
    for (int i = 0; i < 8; i++) if (s == pat[i]) return 8 + i;
    return 0;
  endfunction

  function automatic logic [15:0] model_committed();
    logic [15:0] v;
    for (int d = 0; d < ND; d++) v[4*d +: 4] = 4'(m_comm[d]);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_cand[d] = 0; m_cnt[d] = 0; m_comm[d] = 0;
    end
  endtask

  // Reference filter: run length of identical codes per digit.
  task automatic model_sample(input int d, input logic [6:0] s);
    int code;
    ev_t e;
    code = ref_decode(s);
    if (code == m_cand[d]) m_cnt[d] = (m_cnt[d] + 1 > SC) ? SC : m_cnt[d] + 1;
    else begin
      m_cand[d] = code;
      m_cnt[d]  = 1;
    end
    if (m_cnt[d] == SC && m_cand[d] != m_comm[d]) begin
      m_comm[d] = m_cand[d];
      if (auto_push) begin
        e.idx = d; e.code = code;
        exp_q.push_back(e);
      end
    end
  endtask

  // One bus cycle; onehot_err for this sample is checked just after the edge.
  task automatic scan(input bit v, input logic [6:0] s, input logic [3:0] en);
    bit exp_err;
    int d;
    bus.scan_valid = v;
    bus.seg_in     = s;
    bus.digit_en   = en;
    exp_err = v && ($countones(en) != 1);
    if (v && !exp_err) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (en[i]) d = i;
      model_sample(d, s);
    end
    @(posedge clk);
    #1;
    bus.scan_valid = 1'b0;
    check_eq("onehot_err", onehot_err, exp_err);
  endtask

  task automatic idle(input int n);
    repeat (n) scan(1'b0, 7'd0, 4'd0);
  endtask

  task automatic push_ev(input int idx, input int code);
    ev_t e;
    e.idx = idx; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got index %0d code 0x%0h, expected no event",
                   bus.out_index, {bus.out_known, bus.out_value});
        end else begin
          e = exp_q.pop_front();
          check_eq("event_index", 32'(bus.out_index), e.idx);
          check_eq("event_code", 32'({bus.out_known, bus.out_value}), e.code);
        end
      end
    end
  endtask

  initial begin
    logic [6:0] last_seg [ND];
    logic [3:0] en;
    logic [6:0] s;
    int d;
    pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};
    model_reset();
    auto_push      = 1'b1;
    reset_n        = 1'b0;
    bus.scan_valid = 1'b0;
    bus.seg_in     = 7'd0;
    bus.digit_en   = 4'd0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    fork monitor(); join_none

    // Reset state
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_index", bus.out_index, 2'd0);
    check_eq("rst_out_code", {bus.out_known, bus.out_value}, 4'd0);
    check_eq("rst_committed", committed_values, 16'd0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_onehot_err", onehot_err, 1'b0);

    // Digit 2 shows 3: commit latency t+2, event at t+3
    repeat (3) scan(1'b1, 7'b1001111, 4'b0100);
    check_eq("t1_committed_early", committed_values[11:8], 4'b0000);
    idle(1);
    check_eq("t1_committed", committed_values[11:8], 4'b1011);
    check_eq("t1_valid_early", bus.out_valid, 1'b0);
    idle(1);
    check_eq("t1_valid", bus.out_valid, 1'b1);
    idle(3);

    // Digit 0: unstable 5 then stable 1
    repeat (2) scan(1'b1, 7'b1101101, 4'b0001);
    repeat (3) scan(1'b1, 7'b0000110, 4'b0001);
    idle(4);
    check_eq("t2_committed", committed_values[3:0], 4'b1001);

    // Illegal enables: pulse only, no state change
    scan(1'b1, 7'b0000111, 4'b0011);
    idle(1);
    scan(1'b1, 7'b0000111, 4'b0000);
    idle(3);
    check_eq("t3_committed", committed_values, model_committed());

    // Backpressure: digits 1 and 3 commit while stalled
    auto_push     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) scan(1'b1, 7'b1011011, 4'b0010);
    repeat (3) scan(1'b1, 7'b1100110, 4'b1000);
    idle(4);
    check_eq("t4_valid", bus.out_valid, 1'b1);
    check_eq("t4_index", bus.out_index, 2'd1);
    idle(3);
    check_eq("t4_hold_index", bus.out_index, 2'd1);
    check_eq("t4_hold_code", {bus.out_known, bus.out_value}, 4'b1010);
    push_ev(1, 10);
    push_ev(3, 12);
    bus.out_ready = 1'b1;
    idle(1);
    check_eq("t4_next_valid", bus.out_valid, 1'b1);
    check_eq("t4_next_index", bus.out_index, 2'd3);
    idle(1);
    check_eq("t4_drained", bus.out_valid, 1'b0);

    // Overrun: digit 0 holds the output, digit 1 goes 5 then 6
    bus.out_ready = 1'b0;
    repeat (3) scan(1'b1, 7'b0000111, 4'b0001);
    repeat (3) scan(1'b1, 7'b1101101, 4'b0010);
    idle(3);
    check_eq("t5_no_overrun_yet", overrun, 1'b0);
    repeat (3) scan(1'b1, 7'b1111101, 4'b0010);
    idle(3);
    check_eq("t5_overrun", overrun, 1'b1);
    check_eq("t5_index", bus.out_index, 2'd0);
    push_ev(0, 15);
    push_ev(1, 14);
    bus.out_ready = 1'b1;
    idle(4);
    check_eq("t5_overrun_sticky", overrun, 1'b1);
    check_eq("t5_drained", bus.out_valid, 1'b0);

    // Reset while an event is presented and another is pending
    bus.out_ready = 1'b0;
    repeat (3) scan(1'b1, 7'b0000000, 4'b0100);
    repeat (3) scan(1'b1, 7'b0000111, 4'b1000);
    idle(3);
    check_eq("t6_valid_before", bus.out_valid, 1'b1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    model_reset();
    check_eq("t6_valid", bus.out_valid, 1'b0);
    check_eq("t6_committed", committed_values, 16'd0);
    check_eq("t6_overrun", overrun, 1'b0);
    bus.out_ready = 1'b1;
    idle(10);

    // Random traffic, consumer always ready
    auto_push = 1'b1;
    for (int i = 0; i < ND; i++) last_seg[i] = pat[$urandom_range(0, 7)];
    for (int n = 0; n < 1500; n++) begin
      d = $urandom_range(0, ND - 1);
      if ($urandom_range(0, 9) == 0) en = 4'($urandom_range(0, 15));
      else en = 4'(1 << d);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: s = last_seg[d];
        6, 7, 8:          s = pat[$urandom_range(0, 7)];
        default:          s = 7'($urandom);
      endcase
      last_seg[d] = s;
      scan($urandom_range(0, 3) != 0, s, en);
    end
    idle(4);
    check_eq("rand_committed", committed_values, model_committed());
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
    check_eq("events_outstanding", exp_q.size(), 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
